mem_stage: RTL and testbench
============================

# mem_stage

Fourth pipeline stage of the MIPS core, directly downstream of EX_stage and upstream of WB_stage. Holds the EX/MEM pipeline register, resolves branches and jumps into a redirect for the fetch stage, and runs loads and stores against MainRAM over a req/ack handshake with variable latency. While an access is outstanding it stalls the upstream pipeline and presents a bubble to WB.

## Interface
- TIMEOUT, 16: maximum ACCESS cycles without `mem_ack` before a fatal error; minimum 2.
- CLK  in  1  pipeline clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE  in  1 each  control bits from EX.
- ALUopE  in  6  opcode from EX; passed to WB for jal detection.
- ALUOut_in  in  32  ALU result: memory address, branch flag in bit 0, or jump target.
- WriteData_in  in  32  store data.
- PCPlus4_in, PCBranch_in  in  32 each  link value and branch target.
- wb_addr_in  in  5  destination register.
- mem_req  out  1  access request to MainRAM.
- mem_we  out  1  1 = store.
- mem_addr, mem_wdata  out  32 each  access address and store data.
- mem_rdata  in  32  load data; valid only when `mem_ack` is high.
- mem_ack  in  1  one-cycle access completion.
- stallM  out  1  upstream stages hold when high.
- PCSrcM  out  1  fetch redirect strobe.
- PCTargetM  out  32  redirect target.
- RegWriteM, MemtoRegM  out  1 each  WB controls, gated by validity.
- ALUopM  out  6  opcode to WB.
- ALUOutM, ReadDataM, PCPlus4M  out  32 each  data to WB.
- wb_addrM  out  5  destination register to WB.
- mem_error  out  1  sticky timeout flag.

## Operation
- **Reset.** On RST all registers clear to 0, so the EX/MEM register holds a bubble. State goes to IDLE, the counter to 0, and `mem_error` to 0. Every output is 0, including `mem_req` and `stallM`, and stays 0 while RST is high.
- **Capture.** The EX/MEM register loads every EX input on a rising edge when `stallM` is 0 and holds otherwise.
- **Memory instruction.** A captured instruction is a memory op when `MemtoRegE | MemWriteE`. On the capture edge the FSM moves IDLE → ACCESS; otherwise it stays in IDLE.
- **FSM states.** IDLE, ACCESS, COMPLETE, ERROR.
  - IDLE: the register contents are valid to WB this cycle.
  - ACCESS:
    - Outputs: `mem_req`=1, `mem_we`=`MemWrite_r`, `mem_addr`=`ALUOut_r`, `mem_wdata`=`WriteData_r`. All four are held stable until ack.
    - `stallM`=1 and `RegWriteM`=0.
    - On an edge with `mem_ack`=1: `ReadDataM` ← `mem_rdata` (loads only) and the state moves to COMPLETE.
    - The counter increments on each ACCESS edge without ack. The edge that brings the counter to TIMEOUT moves the state to ERROR and sets `mem_error`.
  - COMPLETE: lasts exactly one cycle. `stallM`=0 and the instruction is valid to WB. The next instruction is captured at the end of the cycle, and the state returns to IDLE or goes to ACCESS according to the new instruction.
  - ERROR: `stallM`=1, `mem_req`=0, and WB outputs form a bubble. The only exit is RST.
- **`mem_ack` outside ACCESS** is ignored.
- **WB outputs.**
  - `RegWriteM` = `RegWrite_r` & valid, where valid = IDLE or COMPLETE. `MemtoRegM` uses the same gating.
  - `ALUOutM`, `ALUopM`, `PCPlus4M` and `wb_addrM` are registered values passed through unchanged.
  - Stores never write back: `RegWrite_r` is 0 for them.
- **Redirect.**
  - `PCSrcM` = valid & ((`Branch_r` & `ALUOut_r[0]`) | `Jump_r`).
  - `PCTargetM` = `Jump_r` ? `ALUOut_r` : `PCBranch_r`.
  - `PCSrcM` is high for exactly one cycle per taken branch or jump. Flushing younger instructions is the hazard unit's responsibility.

## Timing
- **Non-memory instruction:** one cycle in this stage, no stall.
- **Memory access:** occupies 1 capture cycle + N ACCESS cycles + 1 COMPLETE cycle, where N ≥ 1 is the cycle in which `mem_ack` is high. `stallM` is high for exactly N cycles.
- **Control outputs:** `stallM`, `mem_req` and `PCSrcM` are combinational from registered state only, with no combinational path from `mem_ack`.
- **Reset during ACCESS:** `mem_req` drops immediately (asynchronously) and no writeback occurs.
- **Timeout:** `mem_error` rises on the TIMEOUT-th ACCESS edge without ack.

## Structure
- **Package `mem_stage_pkg`:**
  - FSM state enum: IDLE=2'd0, ACCESS=2'd1, COMPLETE=2'd2, ERROR=2'd3.
  - Opcode constants OP_LW, OP_SW, OP_JAL.
  - Timeout counter width, $clog2(TIMEOUT+1).
- **Sub-module `mem_access_fsm`:** the state register, timeout counter, `ReadDataM` capture and handshake outputs. The top level holds the EX/MEM register, validity gating and redirect logic.

## Test plan
- **Reset mid-access:** RST high during ACCESS of an lw → `mem_req`, `stallM` and `RegWriteM` go 0 in the same cycle, and all outputs stay 0 until the next capture.
- **lw with 3-cycle latency:** lw with `ALUOut_in`=0x40, `mem_ack` high in the 3rd ACCESS cycle, `mem_rdata`=0xDEADBEEF → `mem_addr`=0x40 and `stallM` high for exactly 3 cycles. COMPLETE then shows `ReadDataM`=0xDEADBEEF, `RegWriteM`=1, `MemtoRegM`=1.
- **sw with immediate ack:** sw with address 0x80, data 0x12345678, ack in the 1st ACCESS cycle → `mem_we`=1, `stallM` high for 1 cycle, `RegWriteM`=0 throughout.
- **Branches and jumps:**
  - beq with `ALUOut_in`=1, `PCBranch_in`=0x100 → `PCSrcM`=1 for one cycle with `PCTargetM`=0x100.
  - bne with `ALUOut_in`=0 → `PCSrcM`=0.
  - jal with `ALUOut_in`=0x00400020, `PCPlus4_in`=0x1C → `PCTargetM`=0x00400020, `PCPlus4M`=0x1C, `ALUopM`=6'b000011.
- **Timeout:** lw with `mem_ack` held 0 → `mem_error`=1 after exactly 16 ACCESS cycles. `stallM` stays 1 and `mem_req` goes 0 until RST.
- **Back-to-back mix:** add, lw (ack after 2 cycles), sw (ack after 1 cycle), addi sequence → each instruction reaches WB exactly once, in order, with correct data and no duplicated or dropped `RegWriteM` pulses.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: FSM state encoding,
// opcodes that WB cares about, and the timeout counter sizing.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2,
        ERROR    = 2'd3
    } mem_state_e;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_JAL = 6'b000011;

    localparam int TIMEOUT_DEFAULT = 16;
    localparam int TMO_CNT_W       = $clog2(TIMEOUT_DEFAULT + 1);

    // Counter width able to hold the value TIMEOUT itself
    function automatic int tmo_cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Request/acknowledge bus between the MEM stage and MainRAM.
interface mem_stage_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/mem_access_fsm.sv
// Memory access sequencer: owns the IDLE/ACCESS/COMPLETE/ERROR state, the
// ack timeout counter, load data capture and the MainRAM handshake outputs.
// Handshake and stall outputs decode registered state only, so mem_ack never
// reaches an output combinationally.
module mem_access_fsm
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               ex_mem_op,
    input  logic               is_load,
    input  logic               is_store,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    mem_stage_if.master        mem_bus,
    output mem_state_e         state,
    output logic [31:0]        ReadDataM,
    output logic               stallM,
    output logic               mem_error
);

    localparam int CNT_W = tmo_cnt_width(TIMEOUT);

    mem_state_e         state_r;
    mem_state_e         state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic               err_r;
    logic               err_nxt_s;
    logic               rdata_ld_s;
    logic [31:0]        rdata_r;

    // State register, timeout counter, sticky error flag and load data capture
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            err_r   <= 1'b0;
            rdata_r <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            err_r   <= err_nxt_s;
            if (rdata_ld_s) begin
                rdata_r <= mem_bus.mem_rdata;
            end
        end
    end

    // Next-state logic; an instruction is only captured in IDLE or COMPLETE
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        err_nxt_s   = err_r;
        rdata_ld_s  = 1'b0;
        case (state_r)
            IDLE, COMPLETE: begin
                if (ex_mem_op) begin
                    state_nxt_s = ACCESS;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
                if (mem_bus.mem_ack) begin
                    state_nxt_s = COMPLETE;
                    rdata_ld_s  = is_load;
                end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                    state_nxt_s = ERROR;
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                    err_nxt_s   = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end
            end
            ERROR: begin
                state_nxt_s = ERROR;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Handshake and stall outputs decoded from the registered state
    always_comb begin
        mem_bus.mem_req   = 1'b0;
        mem_bus.mem_we    = 1'b0;
        mem_bus.mem_addr  = 32'd0;
        mem_bus.mem_wdata = 32'd0;
        stallM            = 1'b0;
        case (state_r)
            ACCESS: begin
                mem_bus.mem_req   = 1'b1;
                mem_bus.mem_we    = is_store;
                mem_bus.mem_addr  = addr;
                mem_bus.mem_wdata = wdata;
                stallM            = 1'b1;
            end
            ERROR: begin
                stallM            = 1'b1;
            end
            default: begin
                stallM            = 1'b0;
            end
        endcase
    end

    assign state     = state_r;
    assign ReadDataM = rdata_r;
    assign mem_error = err_r;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, writeback validity gating and
// branch/jump redirect. Memory sequencing lives in mem_access_fsm.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RegWriteE,
    input  logic        MemtoRegE,
    input  logic        MemWriteE,
    input  logic        BranchE,
    input  logic        JumpE,
    input  logic [5:0]  ALUopE,
    input  logic [31:0] ALUOut_in,
    input  logic [31:0] WriteData_in,
    input  logic [31:0] PCPlus4_in,
    input  logic [31:0] PCBranch_in,
    input  logic [4:0]  wb_addr_in,
    mem_stage_if.master mem_bus,
    output logic        stallM,
    output logic        PCSrcM,
    output logic [31:0] PCTargetM,
    output logic        RegWriteM,
    output logic        MemtoRegM,
    output logic [5:0]  ALUopM,
    output logic [31:0] ALUOutM,
    output logic [31:0] ReadDataM,
    output logic [31:0] PCPlus4M,
    output logic [4:0]  wb_addrM,
    output logic        mem_error
);

    logic        RegWrite_r;
    logic        MemtoReg_r;
    logic        MemWrite_r;
    logic        Branch_r;
    logic        Jump_r;
    logic [5:0]  ALUop_r;
    logic [31:0] ALUOut_r;
    logic [31:0] WriteData_r;
    logic [31:0] PCPlus4_r;
    logic [31:0] PCBranch_r;
    logic [4:0]  wb_addr_r;

    mem_state_e  state_s;
    logic        valid_s;
    logic        ex_mem_op_s;

    assign ex_mem_op_s = MemtoRegE | MemWriteE;

    // EX/MEM pipeline register; holds while a memory access stalls the pipe
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RegWrite_r  <= 1'b0;
            MemtoReg_r  <= 1'b0;
            MemWrite_r  <= 1'b0;
            Branch_r    <= 1'b0;
            Jump_r      <= 1'b0;
            ALUop_r     <= 6'd0;
            ALUOut_r    <= 32'd0;
            WriteData_r <= 32'd0;
            PCPlus4_r   <= 32'd0;
            PCBranch_r  <= 32'd0;
            wb_addr_r   <= 5'd0;
        end else if (!stallM) begin
            RegWrite_r  <= RegWriteE;
            MemtoReg_r  <= MemtoRegE;
            MemWrite_r  <= MemWriteE;
            Branch_r    <= BranchE;
            Jump_r      <= JumpE;
            ALUop_r     <= ALUopE;
            ALUOut_r    <= ALUOut_in;
            WriteData_r <= WriteData_in;
            PCPlus4_r   <= PCPlus4_in;
            PCBranch_r  <= PCBranch_in;
            wb_addr_r   <= wb_addr_in;
        end
    end

    mem_access_fsm #(
        .TIMEOUT   (TIMEOUT)
    ) u_fsm (
        .CLK       (CLK),
        .RST       (RST),
        .ex_mem_op (ex_mem_op_s),
        .is_load   (MemtoReg_r),
        .is_store  (MemWrite_r),
        .addr      (ALUOut_r),
        .wdata     (WriteData_r),
        .mem_bus   (mem_bus),
        .state     (state_s),
        .ReadDataM (ReadDataM),
        .stallM    (stallM),
        .mem_error (mem_error)
    );

    // Writeback gating and fetch redirect; only IDLE/COMPLETE hold a valid instruction
    always_comb begin
        valid_s   = (state_s == IDLE) || (state_s == COMPLETE);
        RegWriteM = RegWrite_r & valid_s;
        MemtoRegM = MemtoReg_r & valid_s;
        PCSrcM    = valid_s & ((Branch_r & ALUOut_r[0]) | Jump_r);
        if (Jump_r) begin
            PCTargetM = ALUOut_r;
        end else begin
            PCTargetM = PCBranch_r;
        end
    end

    assign ALUopM   = ALUop_r;
    assign ALUOutM  = ALUOut_r;
    assign PCPlus4M = PCPlus4_r;
    assign wb_addrM = wb_addr_r;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a MainRAM responder with programmable
// ack latency, a writeback scoreboard and one task per scenario.
module tb_mem_stage;
    import mem_stage_pkg::*;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic        mw;
        logic        br;
        logic        jp;
        logic [5:0]  op;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
        logic [31:0] pcb;
        logic [4:0]  wa;
    } ex_t;

    typedef struct packed {
        logic [4:0]  wa;
        logic [31:0] data;
    } wb_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE;
    logic [5:0]  ALUopE;
    logic [31:0] ALUOut_in, WriteData_in, PCPlus4_in, PCBranch_in;
    logic [4:0]  wb_addr_in;
    logic        stallM, PCSrcM, RegWriteM, MemtoRegM, mem_error;
    logic [31:0] PCTargetM, ALUOutM, ReadDataM, PCPlus4M;
    logic [5:0]  ALUopM;
    logic [4:0]  wb_addrM;

    mem_stage_if bus();

    mem_stage #(.TIMEOUT(16)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RegWriteE    (RegWriteE),
        .MemtoRegE    (MemtoRegE),
        .MemWriteE    (MemWriteE),
        .BranchE      (BranchE),
        .JumpE        (JumpE),
        .ALUopE       (ALUopE),
        .ALUOut_in    (ALUOut_in),
        .WriteData_in (WriteData_in),
        .PCPlus4_in   (PCPlus4_in),
        .PCBranch_in  (PCBranch_in),
        .wb_addr_in   (wb_addr_in),
        .mem_bus      (bus),
        .stallM       (stallM),
        .PCSrcM       (PCSrcM),
        .PCTargetM    (PCTargetM),
        .RegWriteM    (RegWriteM),
        .MemtoRegM    (MemtoRegM),
        .ALUopM       (ALUopM),
        .ALUOutM      (ALUOutM),
        .ReadDataM    (ReadDataM),
        .PCPlus4M     (PCPlus4M),
        .wb_addrM     (wb_addrM),
        .mem_error    (mem_error)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int wb_seen  = 0;
    wb_t sb_q[$];

    int          ack_lat = 0;
    logic [31:0] rd_val  = 32'd0;
    int          acc_cnt = 0;

    // MainRAM model: ack on the ack_lat-th cycle of a request (0 = never)
    always @(negedge CLK) begin
        if (bus.mem_req === 1'b1) begin
            acc_cnt = acc_cnt + 1;
            if (ack_lat != 0 && acc_cnt == ack_lat) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rd_val;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 32'hBAD0BAD0;
            end
        end else begin
            acc_cnt       = 0;
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 32'hBAD0BAD0;
        end
    end

    wb_t         mon_exp;
    logic [31:0] mon_data;

    // Writeback monitor: every RegWriteM pulse must match the scoreboard head
    always @(negedge CLK) begin
        if (RegWriteM === 1'b1) begin
            wb_seen  = wb_seen + 1;
            n_checks = n_checks + 1;
            if (sb_q.size() == 0) begin
                $display("FAIL wb_unexpected: rd=%0d alu=%h with no writeback expected", wb_addrM, ALUOutM);
            end else begin
                mon_exp  = sb_q.pop_front();
                mon_data = MemtoRegM ? ReadDataM : ((ALUopM == OP_JAL) ? PCPlus4M : ALUOutM);
                if ({wb_addrM, mon_data} !== {mon_exp.wa, mon_exp.data})
                    $display("FAIL wb_data: got rd=%0d data=%h, required rd=%0d data=%h",
                             wb_addrM, mon_data, mon_exp.wa, mon_exp.data);
                else
                    n_pass = n_pass + 1;
            end
        end
    end

    function automatic ex_t mk_ex(input logic rw, input logic m2r, input logic mw,
                                  input logic br, input logic jp, input logic [5:0] op,
                                  input logic [31:0] alu, input logic [31:0] wd,
                                  input logic [31:0] pc4, input logic [31:0] pcb,
                                  input logic [4:0] wa);
        ex_t e;
        e.rw = rw; e.m2r = m2r; e.mw = mw; e.br = br; e.jp = jp; e.op = op;
        e.alu = alu; e.wd = wd; e.pc4 = pc4; e.pcb = pcb; e.wa = wa;
        return e;
    endfunction

    task automatic set_ex(input ex_t e);
        RegWriteE    = e.rw;
        MemtoRegE    = e.m2r;
        MemWriteE    = e.mw;
        BranchE      = e.br;
        JumpE        = e.jp;
        ALUopE       = e.op;
        ALUOut_in    = e.alu;
        WriteData_in = e.wd;
        PCPlus4_in   = e.pc4;
        PCBranch_in  = e.pcb;
        wb_addr_in   = e.wa;
    endtask

    // Drive one instruction at the first negedge with no stall; record its writeback
    task automatic issue(input ex_t e, input int lat, input logic [31:0] rdata,
                         input bit push, input logic [31:0] exp_data);
        int n;
        @(negedge CLK);
        n = 0;
        while (stallM === 1'b1 && n < 64) begin
            @(negedge CLK);
            n++;
        end
        if (stallM === 1'b1) begin
            n_checks++;
            $display("FAIL issue_wait: stallM=%b after %0d cycles, required 0", stallM, n);
        end
        ack_lat = lat;
        rd_val  = rdata;
        set_ex(e);
        if (push) sb_q.push_back({e.wa, exp_data});
    endtask

    task automatic test_reset();
        set_ex(mk_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 32'h0000_0011, 32'd5,
                     32'd8, 32'd12, 5'd3));
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        n_checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, stallM, PCSrcM, PCTargetM,
             RegWriteM, MemtoRegM, ALUopM, ALUOutM, ReadDataM, PCPlus4M, wb_addrM, mem_error} !== '0)
            $display("FAIL reset_outputs: req=%b stall=%b rw=%b alu=%h tgt=%h err=%b, required all 0",
                     bus.mem_req, stallM, RegWriteM, ALUOutM, PCTargetM, mem_error);
        else n_pass++;
        set_ex('0);
        RST = 1'b0;
        @(negedge CLK);
        n_checks++;
        if ({stallM, RegWriteM, bus.mem_req, PCSrcM, mem_error} !== 5'b0)
            $display("FAIL reset_release: stall=%b rw=%b req=%b pcsrc=%b err=%b, required 0",
                     stallM, RegWriteM, bus.mem_req, PCSrcM, mem_error);
        else n_pass++;
    endtask

    task automatic test_lw_latency();
        int stall_n = 0;
        int bad = 0;
        bit done = 0;
        issue(mk_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OP_LW, 32'h40, 32'd0, 32'h4, 32'd0, 5'd5),
              3, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge CLK);
            set_ex('0);
            if (stallM === 1'b1) begin
                stall_n++;
                if (bus.mem_addr !== 32'h40 || bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 ||
                    RegWriteM !== 1'b0) bad++;
            end else begin
                done = 1;
                n_checks++;
                if ({ReadDataM, RegWriteM, MemtoRegM} !== {32'hDEADBEEF, 1'b1, 1'b1})
                    $display("FAIL lw_complete: rdata=%h rw=%b m2r=%b, required deadbeef 1 1",
                             ReadDataM, RegWriteM, MemtoRegM);
                else n_pass++;
            end
        end
        n_checks++;
        if (!done) $display("FAIL lw_done: access did not finish within 20 cycles");
        else n_pass++;
        n_checks++;
        if (stall_n !== 3) $display("FAIL lw_stall_len: got %0d cycles, required 3", stall_n);
        else n_pass++;
        n_checks++;
        if (bad !== 0) $display("FAIL lw_access_bus: %0d cycles with wrong req/addr/we/rw", bad);
        else n_pass++;
    endtask

    task automatic test_sw_immediate();
        int stall_n = 0;
        int bad = 0;
        bit done = 0;
        issue(mk_ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, OP_SW, 32'h80, 32'h12345678, 32'h8,
                    32'd0, 5'd0), 1, 32'd0, 1'b0, 32'd0);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge CLK);
            set_ex('0);
            if (RegWriteM !== 1'b0) bad++;
            if (stallM === 1'b1) begin
                stall_n++;
                if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !==
                    {1'b1, 1'b1, 32'h80, 32'h12345678}) bad++;
            end else begin
                done = 1;
            end
        end
        @(negedge CLK);
        if (RegWriteM !== 1'b0) bad++;
        n_checks++;
        if (!done || stall_n !== 1)
            $display("FAIL sw_stall_len: done=%0d got %0d cycles, required 1", done, stall_n);
        else n_pass++;
        n_checks++;
        if (bad !== 0) $display("FAIL sw_bus: %0d bad cycles (bus fields or RegWriteM)", bad);
        else n_pass++;
    endtask

    task automatic test_branch_jump();
        issue(mk_ex(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000100, 32'd1, 32'd0, 32'h4,
                    32'h100, 5'd0), 0, 32'd0, 1'b0, 32'd0);
        @(negedge CLK);
        set_ex('0);
        n_checks++;
        if ({PCSrcM, PCTargetM} !== {1'b1, 32'h100})
            $display("FAIL beq_taken: pcsrc=%b tgt=%h, required 1 00000100", PCSrcM, PCTargetM);
        else n_pass++;
        @(negedge CLK);
        n_checks++;
        if (PCSrcM !== 1'b0) $display("FAIL beq_one_cycle: pcsrc=%b, required 0", PCSrcM);
        else n_pass++;

        issue(mk_ex(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000101, 32'd0, 32'd0, 32'h4,
                    32'h200, 5'd0), 0, 32'd0, 1'b0, 32'd0);
        @(negedge CLK);
        set_ex('0);
        n_checks++;
        if (PCSrcM !== 1'b0) $display("FAIL bne_not_taken: pcsrc=%b, required 0", PCSrcM);
        else n_pass++;

        issue(mk_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, OP_JAL, 32'h00400020, 32'd0, 32'h1C,
                    32'h300, 5'd31), 0, 32'd0, 1'b1, 32'h1C);
        @(negedge CLK);
        set_ex('0);
        n_checks++;
        if ({PCSrcM, PCTargetM, PCPlus4M, ALUopM} !== {1'b1, 32'h00400020, 32'h1C, 6'b000011})
            $display("FAIL jal: pcsrc=%b tgt=%h pc4=%h op=%b, required 1 00400020 0000001c 000011",
                     PCSrcM, PCTargetM, PCPlus4M, ALUopM);
        else n_pass++;
        @(negedge CLK);
        n_checks++;
        if (PCSrcM !== 1'b0) $display("FAIL jal_one_cycle: pcsrc=%b, required 0", PCSrcM);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int req_n = 0;
        bit hit = 0;
        issue(mk_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OP_LW, 32'h50, 32'd0, 32'h4, 32'd0, 5'd7),
              0, 32'd0, 1'b0, 32'd0);
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge CLK);
            set_ex('0);
            if (mem_error === 1'b1) hit = 1;
            else if (bus.mem_req === 1'b1) req_n++;
        end
        n_checks++;
        if (!hit || req_n !== 16)
            $display("FAIL timeout_len: err=%0d after %0d access cycles, required 1 after 16", hit, req_n);
        else n_pass++;
        n_checks++;
        if ({stallM, bus.mem_req, RegWriteM} !== 3'b100)
            $display("FAIL timeout_outputs: stall=%b req=%b rw=%b, required 1 0 0",
                     stallM, bus.mem_req, RegWriteM);
        else n_pass++;
        repeat (3) @(negedge CLK);
        n_checks++;
        if ({stallM, bus.mem_req, mem_error, RegWriteM} !== 4'b1010)
            $display("FAIL error_sticky: stall=%b req=%b err=%b rw=%b, required 1 0 1 0",
                     stallM, bus.mem_req, mem_error, RegWriteM);
        else n_pass++;
    endtask

    task automatic test_reset_mid_access();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        n_checks++;
        if ({mem_error, stallM} !== 2'b00)
            $display("FAIL error_cleared: err=%b stall=%b, required 0 0", mem_error, stallM);
        else n_pass++;
        issue(mk_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OP_LW, 32'h60, 32'd0, 32'h4, 32'd0, 5'd6),
              0, 32'd0, 1'b0, 32'd0);
        @(negedge CLK);
        set_ex('0);
        n_checks++;
        if ({bus.mem_req, stallM} !== 2'b11)
            $display("FAIL rst_pre_access: req=%b stall=%b, required 1 1", bus.mem_req, stallM);
        else n_pass++;
        #2 RST = 1'b1;
        #1;
        n_checks++;
        if ({bus.mem_req, stallM, RegWriteM} !== 3'b000)
            $display("FAIL rst_async_drop: req=%b stall=%b rw=%b, required 0 0 0",
                     bus.mem_req, stallM, RegWriteM);
        else n_pass++;
        @(negedge CLK);
        n_checks++;
        if ({bus.mem_req, bus.mem_addr, stallM, RegWriteM, MemtoRegM, ALUOutM, wb_addrM,
             PCSrcM, mem_error} !== '0)
            $display("FAIL rst_hold: req=%b addr=%h stall=%b rw=%b alu=%h, required all 0",
                     bus.mem_req, bus.mem_addr, stallM, RegWriteM, ALUOutM);
        else n_pass++;
        RST = 1'b0;
        @(negedge CLK);
        n_checks++;
        if ({bus.mem_req, stallM, RegWriteM, mem_error} !== 4'b0000)
            $display("FAIL rst_after: req=%b stall=%b rw=%b err=%b, required 0",
                     bus.mem_req, stallM, RegWriteM, mem_error);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int start_wb;
        start_wb = wb_seen;
        issue(mk_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h11, 32'd0, 32'h20, 32'd0, 5'd8),
              0, 32'd0, 1'b1, 32'h11);
        issue(mk_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OP_LW, 32'h44, 32'd0, 32'h24, 32'd0, 5'd9),
              2, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D);
        issue(mk_ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, OP_SW, 32'h48, 32'h55, 32'h28, 32'd0, 5'd0),
              1, 32'd0, 1'b0, 32'd0);
        issue(mk_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b001000, 32'h22, 32'd0, 32'h2C, 32'd0,
                    5'd10), 0, 32'd0, 1'b1, 32'h22);
        issue('0, 0, 32'd0, 1'b0, 32'd0);
        repeat (4) @(negedge CLK);
        n_checks++;
        if (wb_seen - start_wb !== 3)
            $display("FAIL b2b_wb_count: got %0d writebacks, required 3", wb_seen - start_wb);
        else n_pass++;
    endtask

    initial begin
        set_ex('0);
        test_reset();
        test_lw_latency();
        test_sw_immediate();
        test_branch_jump();
        test_back_to_back();
        test_timeout();
        test_reset_mid_access();
        n_checks++;
        if (sb_q.size() !== 0) $display("FAIL sb_empty: %0d writebacks never seen", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
